// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// UART_TX_PARITY_EN adds an even-parity bit to every frame.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int unsigned DEFAULT_CLK_PER_BIT = 868;

`ifdef UART_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif

endpackage

// File: rtl/uart_tx_fifo_byte_fifo.sv
// Byte FIFO with a registered occupancy count; dout shows the head entry combinationally.
// A push while full is dropped, even if a pop happens on the same edge.
module byte_fifo #(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == DEPTH_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rptr_q];

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a baud-timed serializer, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       we,
    input  logic [7:0] wdata,
    output logic       full,
    output logic       busy,
    output logic       txd
);

    localparam logic [15:0] BAUD_LOAD = 16'(CLK_PER_BIT - 1);

    tx_state_t   state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        txd_q, txd_d;
    logic        baud_tick;
    logic        fifo_pop, fifo_empty;
    logic [7:0]  fifo_dout;
`ifdef UART_TX_PARITY_EN
    logic        par_q, par_d;
`endif

    byte_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rstn (rstn),
        .push (we),
        .din  (wdata),
        .pop  (fifo_pop),
        .dout (fifo_dout),
        .empty(fifo_empty),
        .full (full)
    );

    assign baud_tick = (baud_q == '0);
    assign busy      = (state_q != IDLE) || !fifo_empty;
    assign txd       = txd_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
`endif
        if (state_q != IDLE && !baud_tick) begin
            baud_d = baud_q - 1'b1;
        end else begin
            case (state_q)
                IDLE, STOP: begin
                    // STOP shares IDLE's pop path so back-to-back frames have no idle gap
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        state_d  = START;
                        baud_d   = BAUD_LOAD;
`ifdef UART_TX_PARITY_EN
                        par_d    = ^fifo_dout;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
                START: begin
                    state_d = DATA;
                    baud_d  = BAUD_LOAD;
                    bit_d   = '0;
                end
                DATA: begin
                    baud_d  = BAUD_LOAD;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    state_d = STOP;
                    baud_d  = BAUD_LOAD;
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    // txd is registered from the next state so the pin never glitches
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd_d = par_d;
`endif
            default: txd_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue plus frame-timer reference model checked every cycle.
// Honours UART_TX_PARITY_EN for the frame length and parity bit.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FL = FB * CPB;

    logic       clk   = 1'b0;
    logic       rstn  = 1'b0;
    logic       we    = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       full, busy, txd;

    uart_tx_fifo #(
        .CLK_PER_BIT(CPB),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .we   (we),
        .wdata(wdata),
        .full (full),
        .busy (busy),
        .txd  (txd)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: queued bytes, the byte on the wire, cycles left in its frame
    logic [7:0] mq[$];
    logic [7:0] cur = 8'h00;
    int         frame_left = 0;

    task automatic model_edge(input logic r, input logic w, input logic [7:0] d);
        bit was_empty;
        bit was_full;
        was_empty = (mq.size() == 0);
        was_full  = (mq.size() == DEPTH);
        if (!r) begin
            mq.delete();
            frame_left = 0;
            return;
        end
        if (frame_left == 0) begin
            if (!was_empty) begin
                cur = mq.pop_front();
                frame_left = FL;
            end
        end else begin
            frame_left--;
            if (frame_left == 0 && !was_empty) begin
                cur = mq.pop_front();
                frame_left = FL;
            end
        end
        if (w && !was_full) mq.push_back(d);
    endtask

    function automatic logic exp_txd();
        int idx;
        if (frame_left == 0) return 1'b1;
        idx = (FL - frame_left) / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return cur[idx-1];
        if (FB == 11 && idx == 9) return ^cur;
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b at t=%0t", tag, obs, expv, $time);
        end
    endtask

    task automatic cycle(input logic r, input logic w, input logic [7:0] d);
        rstn  = r;
        we    = w;
        wdata = d;
        @(posedge clk);
        model_edge(r, w, d);
        #1;
        check("txd", txd, exp_txd());
        check("busy", busy, (frame_left != 0) || (mq.size() != 0));
        check("full", full, mq.size() == DEPTH);
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (!(frame_left == 0 && mq.size() == 0) && n < bound) begin
            cycle(1'b1, 1'b0, 8'h00);
            n++;
        end
        checks++;
        assert (frame_left == 0 && mq.size() == 0) else begin
            errors++;
            $error("FAIL drain_timeout: observed=not idle expected=idle within %0d cycles", bound);
        end
        cycle(1'b1, 1'b0, 8'h00);
        check("idle_busy", busy, 1'b0);
        check("idle_txd", txd, 1'b1);
    endtask

    task automatic wait_frame_bit(input int idx, input int bound);
        int n = 0;
        while (!(frame_left > 0 && (FL - frame_left) / CPB == idx) && n < bound) begin
            cycle(1'b1, 1'b0, 8'h00);
            n++;
        end
        checks++;
        assert (frame_left > 0 && (FL - frame_left) / CPB == idx) else begin
            errors++;
            $error("FAIL wait_bit_timeout: observed=not reached expected=frame bit %0d", idx);
        end
    endtask

    task automatic wait_stop_end(input int bound);
        int n = 0;
        while (frame_left != 1 && n < bound) begin
            cycle(1'b1, 1'b0, 8'h00);
            n++;
        end
        checks++;
        assert (frame_left == 1) else begin
            errors++;
            $error("FAIL wait_stop_timeout: observed=not reached expected=last stop cycle");
        end
    endtask

    initial begin
        int hi;
        logic r, w;
        logic [7:0] d;

        // Reset state
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'hEE);
        check("rst_txd", txd, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_full", full, 1'b0);

        // Single byte: latency and whole-frame busy duration
        cycle(1'b1, 1'b1, 8'h55);
        check("busy_after_write", busy, 1'b1);
        hi = 1;
        cycle(1'b1, 1'b0, 8'h00);
        check("start_latency", txd, 1'b0);
        while (busy === 1'b1 && hi < 200) begin
            hi++;
            cycle(1'b1, 1'b0, 8'h00);
        end
        checks++;
        assert (hi == FL + 1) else begin
            errors++;
            $error("FAIL busy_span: observed=%0d expected=%0d", hi, FL + 1);
        end
        drain(10);

        // Back-to-back frames
        cycle(1'b1, 1'b1, 8'hA3);
        cycle(1'b1, 1'b1, 8'h0F);
        drain(4 * FL);

        // Parity-relevant pattern
        cycle(1'b1, 1'b1, 8'h07);
        drain(2 * FL);

        // Overflow: sixth write is dropped
        for (int i = 1; i <= 6; i++) begin
            cycle(1'b1, 1'b1, 8'(i));
            if (i == 5) check("ovf_full", full, 1'b1);
        end
        drain(8 * FL);

        // Reset during data bit 3 of 0xFF with two bytes queued
        cycle(1'b1, 1'b1, 8'hFF);
        cycle(1'b1, 1'b1, 8'h11);
        cycle(1'b1, 1'b1, 8'h22);
        wait_frame_bit(4, 2 * FL);
        cycle(1'b0, 1'b0, 8'h00);
        check("midrst_txd", txd, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_full", full, 1'b0);
        for (int i = 0; i < 60; i++) cycle(1'b1, 1'b0, 8'h00);

        // Push and pop on the same edge with DEPTH-1 queued
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b1, 8'(8'h31 + i));
        wait_stop_end(2 * FL);
        cycle(1'b1, 1'b1, 8'h5A);
        check("pushpop_full", full, 1'b0);
        drain((DEPTH + 2) * FL);

        // Randomized traffic with occasional resets
        for (int round = 0; round < 3; round++) begin
            for (int i = 0; i < 120; i++) begin
                r = ($urandom_range(0, 149) != 0);
                w = ($urandom_range(0, 2) == 0);
                d = 8'($urandom);
                cycle(r, w, d);
            end
            drain((DEPTH + 2) * FL);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered UART transmitter for the core's output path; the core's `out` instruction writes one byte per cycle into it.
- Bytes are queued in a small FIFO and serialized onto txd as 8N1 frames, LSB first.
- Sits between the core's I/O write port and the board TX pin.
- Mirrors the existing UART receive path, in the transmit direction.

Parameters:
- CLK_PER_BIT, 868, clock cycles per bit (100 MHz / 115200 baud); legal range 2..65535.
- FIFO_DEPTH, 16, byte entries; power of two, 2..256.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rstn  input  1  synchronous active-low reset.
- we  input  1  write strobe from core; sampled each rising edge.
- wdata  input  8  byte to transmit; valid when we=1.
- full  output  1  FIFO holds FIFO_DEPTH bytes; core must stall while 1.
- busy  output  1  frame in progress OR FIFO non-empty.
- txd  output  1  serial line, idle high.

Behaviour:
- Reset, rstn=0 at an edge: txd=1, full=0, busy=0; FIFO emptied; FSM to IDLE; baud and bit counters cleared.
  - Reset mid-frame aborts the frame; txd=1 after that edge; queued bytes are discarded.
- FIFO:
  - Write occurs when we=1 and full=0.
  - A write while full=1 is dropped silently; the contents are unchanged.
  - full and the empty flag derive from a registered count of log2(FIFO_DEPTH)+1 bits.
  - Simultaneous push and pop leaves the count unchanged.
  - A push into an empty FIFO is not popped in the same cycle.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP, plus PARITY under the optional feature.
  - IDLE: txd=1. If the FIFO is non-empty at an edge: pop the head into an 8-bit shift register, go to START, load the baud counter.
  - START: txd=0 for CLK_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: txd=shift[0] for CLK_PER_BIT cycles per bit; shift right after each bit. After bit index 7, go to STOP.
  - STOP: txd=1 for CLK_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter: counts CLK_PER_BIT-1 down to 0; the state or bit advances on the edge where it reads 0.
- txd is driven from a flop (glitch-free). A frame is exactly 10*CLK_PER_BIT cycles.
- Latency: a byte written at edge E0 into an empty, idle block gives txd=0 starting after edge E1 (one cycle).
- busy=1 from the edge after the first write until the end of the final STOP bit with the FIFO empty.
- wdata is ignored when we=0. There is no read-back path.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP.
  - txd = XOR of the 8 data bits (even parity) for CLK_PER_BIT cycles.
  - Frame becomes 11*CLK_PER_BIT cycles.
- Undefined: no PARITY state, no parity logic; 8N1 as above.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [2:0] tx_state_t {IDLE, START, DATA, PARITY, STOP}.
  - Localparam DEFAULT_CLK_PER_BIT=868.
  - Localparam FRAME_BITS (10, or 11 with parity), for the bench.
- Sub-module byte_fifo:
  - Parameterized on FIFO_DEPTH.
  - Ports clk, rstn, push, din[7:0], pop, dout[7:0], empty, full.
  - dout is combinational from the head entry.
- The FSM and baud counter stay in uart_tx_fifo.

Test Plan (all with CLK_PER_BIT=4, FIFO_DEPTH=4):
- Single byte: write 0x55 once.
  - txd falls one cycle later.
  - Sequence 0,1,0,1,0,1,0,1,0,1 is held 4 cycles each (40 cycles total).
  - busy drops the cycle after the stop bit ends.
- Back-to-back: write 0xA3 then 0x0F on consecutive cycles.
  - Two frames with no idle gap; LSB-first bits 1,1,0,0,0,1,0,1 then 1,1,1,1,0,0,0,0.
- Overflow: write 6 bytes 0x01..0x06 on consecutive cycles.
  - full asserts once the FIFO holds 4 bytes; the dropped writes are not transmitted.
  - The transmitted bytes are exactly those accepted, in order. Bench model: byte 0x01 is popped the cycle after its write, so 0x01..0x05 are sent and 0x06 is dropped.
- Reset mid-frame: assert rstn=0 for 1 cycle during DATA bit 3 of 0xFF with 2 bytes queued.
  - txd=1 next edge; busy=0, full=0.
  - No further frames follow.
- Push/pop same edge: with FIFO_DEPTH-1 bytes queued, write at the edge where STOP ends and a pop occurs.
  - full stays 0; the byte is accepted and sent last.
- Parity (UART_TX_PARITY_EN defined): write 0x07.
  - Parity bit = 1; frame is 44 cycles, with stop bit 1 after parity.
